// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART_IO subsystem PIO poller.
package uart_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        EVAL = 2'd3
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_OFS = 2'd0;
    localparam int         AVM_DATA_W   = 32;

    // Count up towards lim and hold there.
    function automatic logic [7:0] sat_inc8(input logic [7:0] c, input logic [7:0] lim);
        return (c >= lim) ? lim : c + 8'd1;
    endfunction

endpackage

// File: rtl/uart_io_poll_divider.sv
// Free-running modulo-POLL_DIV counter; o_tc is high while the count sits at POLL_DIV-1.
module uart_io_poll_divider #(
    parameter int POLL_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tc
);

    localparam int               CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_cnt <= '0;
        else if (o_tc) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_io_pio_poller.sv
// Avalon-MM poller of the switch PIO with debounce, change strobe and waitrequest timeout.
// Debounce is built only when POLLER_DEBOUNCE_EN is defined; otherwise value follows each sample.
module uart_io_pio_poller
    import uart_io_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int POLL_DIV   = 50000,
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0]     value,
    output logic                  changed,
    output logic                  sample_valid,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    poll_state_t       r_state, w_state_nxt;
    logic              w_tc;
    logic              w_to_fire;
    logic [15:0]       r_to_cnt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] w_new_val;
    logic              w_upd;
    logic              r_changed;
    logic              r_timeout_err;
    logic              w_unused_rd;

    assign w_unused_rd = ^avm_readdata[AVM_DATA_W-1:DATA_W];

    uart_io_poll_divider #(.POLL_DIV(POLL_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // A terminal count seen outside IDLE is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_to_fire   = 1'b0;
        case (r_state)
            IDLE: if (w_tc && enable) w_state_nxt = REQ;
            REQ: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = RESP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = IDLE;
                    w_to_fire   = 1'b1;
                end
            end
            RESP:    w_state_nxt = EVAL;
            EVAL:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_sample      <= '0;
        end else begin
            r_timeout_err <= w_to_fire;
            if (r_state == REQ && avm_waitrequest) r_to_cnt <= r_to_cnt + 16'd1;
            else                                   r_to_cnt <= '0;
            if (r_state == RESP) r_sample <= avm_readdata[DATA_W-1:0];
        end
    end

`ifdef POLLER_DEBOUNCE_EN
    localparam logic [7:0] STABLE = 8'(STABLE_CNT);

    logic [DATA_W-1:0] r_cand, w_cand_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (r_sample != r_cand) begin
            w_cand_nxt = r_sample;
            w_cnt_nxt  = 8'd1;
        end else begin
            w_cnt_nxt  = sat_inc8(r_cnt, STABLE);
        end
    end

    assign w_new_val = w_cand_nxt;
    assign w_upd     = (w_cnt_nxt == STABLE) && (w_cand_nxt != r_value);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (r_state == EVAL) begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end
`else
    logic [7:0] w_unused_stable;

    assign w_unused_stable = 8'(STABLE_CNT);
    assign w_new_val       = r_sample;
    assign w_upd           = (r_sample != r_value);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value   <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_state == EVAL && w_upd) begin
                r_value   <= w_new_val;
                r_changed <= 1'b1;
            end
        end
    end

    // Read strobe decodes straight from the state flops so reset drops it at once.
    assign avm_address  = PIO_DATA_OFS;
    assign avm_read     = (r_state == REQ);
    assign sample_valid = (r_state == RESP);
    assign busy         = (r_state != IDLE);
    assign value        = r_value;
    assign changed      = r_changed;
    assign timeout_err  = r_timeout_err;

endmodule
